mac_pipe_sat: RTL and testbench
===============================

# mac_pipe_sat

Parametrised, fully pipelined signed multiply-accumulate unit with saturating accumulator, per-sample accumulator clear and a sticky overflow flag. It is the generalised successor of the fixed 10x10/20-bit pipelined MAC: operand, accumulator width and multiplier depth are parameters. It accepts one sample per cycle with a valid tag and sits between a sample source (filter tap or matrix-row streamer) and a result consumer that samples `f` on `valid_out`.

## Interface
- `A_W`, 10, signed width of operand `a` (≥2)
- `B_W`, 10, signed width of operand `b` (≥2)
- `ACC_W`, 20, signed accumulator/output width; must satisfy `ACC_W >= A_W+B_W`
- `MULT_STAGES`, 5, number of register stages inside the multiplier (≥1)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `a` in A_W: signed operand
- `b` in B_W: signed operand
- `valid_in` in 1: sample (`a`, `b`, `clear_in`) valid this cycle
- `clear_in` in 1: this sample starts a new accumulation; ignored when `valid_in`=0
- `f` out ACC_W: signed accumulator value
- `valid_out` out 1: one-cycle pulse, `f` just updated by one sample
- `overflow` out 1: sticky, a saturation occurred since last clear/reset

## Operation
- Stage 0 (input register): on `valid_in`=1, capture `a`, `b`, `clear_in`. Operand registers hold when `valid_in`=0. Valid and clear tags enter a shift pipeline every cycle.
- Multiplier: behavioural signed `A_W x B_W` product with exactly `MULT_STAGES` register stages. Product width is `A_W+B_W`. Its output is then registered once more into a product register.
- Tags: the valid/clear shift pipeline has `MULT_STAGES+1` stages, aligned so that the tag reaches the accumulator in the same cycle as its product. Invalid slots never modify `f` or `overflow`.
- Accumulate, when the aligned tag is valid:
  - sign-extend the product to `ACC_W+1` bits
  - base = 0 if clear tag is set, else `f` sign-extended to `ACC_W+1`
  - sum = base + product
  - if sum > 2^(ACC_W-1)-1 then `f` ← 2^(ACC_W-1)-1 (default 524287)
  - else if sum < -2^(ACC_W-1) then `f` ← -2^(ACC_W-1) (default -524288)
  - else `f` ← sum
- Overflow flag:
  - Saturation sets `overflow`.
  - An accepted clear sample sets `overflow` to that sample's own saturation result. Note that with `ACC_W >= A_W+B_W` a clear sample cannot saturate, so this always writes 0.
  - Otherwise `overflow` holds.
- `valid_out` is 1 in the cycle after each accumulator update, else 0.
- Once saturated, `f` stays clamped until later samples bring the true sum back in range. There is no wrap-around.

## Timing
- Reset values: `f`=0, `valid_out`=0, `overflow`=0. All tag stages, operand registers and the product register are cleared.
- Latency: a sample presented with `valid_in`=1 in cycle t appears on `f` with `valid_out`=1 in cycle t+`MULT_STAGES`+2 (default t+7).
- Throughput: one sample per cycle, no backpressure and no stall. Gaps in `valid_in` propagate as gaps in `valid_out`. Output order matches input order.
- Reset asserted mid-stream discards all in-flight samples. No `valid_out` pulse occurs for samples accepted before or during reset. The first `valid_out` after reset deassertion belongs to a sample accepted after deassertion.
- `clear_in` without `valid_in` has no effect.
- When a clear sample is immediately followed by normal samples, the normal samples accumulate onto the cleared value with no bubble.
- `f` and `overflow` change only in cycles where `valid_out` is 1 (or on reset).

## Test plan
- Reset, then samples (3,4,clear=1), (-2,5,0), (7,-1,0) on consecutive cycles -> `valid_out` pulses at t+7, t+8, t+9 with `f`=12, 2, -5; `overflow`=0.
- Positive saturation: (-512,-512,clear=1) then (-512,-512,0) -> `f`=262144, then 524287 with `overflow`=1. A following (1,-1,0) -> `f`=524286, `overflow` still 1.
- Negative saturation: three samples (511,-512), the first with clear -> `f`=-261632, then -523264, then -524288 with `overflow`=1. A following clear sample (2,3,1) -> `f`=6, `overflow`=0.
- Gapped input: valid on cycles 0, 3, 4 with (1,1,clear=1), (2,2,0), (3,3,0) -> pulses at cycles 7, 10, 11 with `f`=1, 5, 14. No pulse on cycles 8–9, and `f` holds 1 during them.
- Reset mid-stream: 4 valid samples, then `reset` high 1 cycle at cycle 3 -> no `valid_out` for any of them, `f`=0. A new sample (5,5,clear=0) -> `f`=25 at 7 cycles after acceptance.
- Parameter sweep: `MULT_STAGES`=1 and 8, `A_W`=`B_W`=16, `ACC_W`=40 -> latency is 3 and 10 cycles respectively. Random streams match a saturating reference model bit-exactly.

Source files
------------

// File: rtl/mac_pipe_sat_if.sv
// rtl/mac_pipe_sat_if.sv - sample/result bundle between a MAC source/consumer and mac_pipe_sat
interface mac_pipe_sat_if #(
   parameter int A_W   = 10,
   parameter int B_W   = 10,
   parameter int ACC_W = 20
);
   logic signed [A_W-1:0]   a;
   logic signed [B_W-1:0]   b;
   logic                    valid_in;
   logic                    clear_in;
   logic signed [ACC_W-1:0] f;
   logic                    valid_out;
   logic                    overflow;

   // Sample source / result consumer side
   modport master (
      output a, b, valid_in, clear_in,
      input  f, valid_out, overflow
   );

   // MAC side
   modport slave (
      input  a, b, valid_in, clear_in,
      output f, valid_out, overflow
   );
endinterface

// File: rtl/mac_pipe_sat.sv
// rtl/mac_pipe_sat.sv - pipelined signed MAC with saturating accumulator and sticky overflow
module mac_pipe_sat #(
   parameter int A_W         = 10,
   parameter int B_W         = 10,
   parameter int ACC_W       = 20,
   parameter int MULT_STAGES = 5
) (
   input logic          clk,
   input logic          reset,
   mac_pipe_sat_if.slave bus
);
   localparam int P_W = A_W + B_W;
   // Tag depth: one slot alongside the operand registers plus one per
   // multiplier stage plus the product register, so the tag leaving the last
   // slot sits in the same cycle as the product it describes.
   localparam int T_W = MULT_STAGES + 2;

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [A_W-1:0]   a_q, a_d;
   logic signed [B_W-1:0]   b_q, b_d;
   logic [T_W-1:0]          vld_q, vld_d;
   logic [T_W-1:0]          clr_q, clr_d;
   logic signed [P_W-1:0]   mult_q [MULT_STAGES];
   logic signed [P_W-1:0]   mult_d [MULT_STAGES];
   logic signed [P_W-1:0]   prod_q, prod_d;
   logic signed [ACC_W-1:0] f_q, f_d;
   logic                    valid_out_q, valid_out_d;
   logic                    overflow_q, overflow_d;

   logic signed [ACC_W:0]   prod_ext;
   logic signed [ACC_W:0]   base;
   logic signed [ACC_W:0]   sum;
   logic                    sat;
   logic                    acc_vld;
   logic                    acc_clr;

   // Operand capture (held across idle cycles) and tag shift-in every cycle
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (bus.valid_in) begin
         a_d = bus.a;
         b_d = bus.b;
      end
      vld_d = {vld_q[T_W-2:0], bus.valid_in};
      clr_d = {clr_q[T_W-2:0], bus.valid_in & bus.clear_in};
   end

   // Multiplier: product formed in the first stage, then carried through the rest
   always_comb begin
      mult_d[0] = P_W'(a_q) * P_W'(b_q);
      for (int i = 1; i < MULT_STAGES; i++) begin
         mult_d[i] = mult_q[i-1];
      end
      prod_d = mult_q[MULT_STAGES-1];
   end

   // Accumulate one guard bit wide so the clamp decision is a simple sign check
   always_comb begin
      acc_vld     = vld_q[T_W-1];
      acc_clr     = clr_q[T_W-1];
      prod_ext    = {{(ACC_W+1-P_W){prod_q[P_W-1]}}, prod_q};
      base        = acc_clr ? '0 : {f_q[ACC_W-1], f_q};
      sum         = base + prod_ext;
      // Top two bits disagree exactly when the sum left the ACC_W range.
      sat         = sum[ACC_W] ^ sum[ACC_W-1];
      f_d         = f_q;
      overflow_d  = overflow_q;
      valid_out_d = acc_vld;
      if (acc_vld) begin
         if (sat) begin
            f_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
         end else begin
            f_d = sum[ACC_W-1:0];
         end
         // A clear sample restarts the sticky flag from its own result.
         overflow_d = acc_clr ? sat : (overflow_q | sat);
      end
   end

   // State registers with synchronous reset flushing every in-flight sample
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         vld_q       <= '0;
         clr_q       <= '0;
         for (int i = 0; i < MULT_STAGES; i++) begin
            mult_q[i] <= '0;
         end
         prod_q      <= '0;
         f_q         <= '0;
         valid_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         vld_q       <= vld_d;
         clr_q       <= clr_d;
         for (int i = 0; i < MULT_STAGES; i++) begin
            mult_q[i] <= mult_d[i];
         end
         prod_q      <= prod_d;
         f_q         <= f_d;
         valid_out_q <= valid_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.f         = f_q;
   assign bus.valid_out = valid_out_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mac_pipe_sat.sv
// tb/tb_mac_pipe_sat.sv - directed and model-checked bench for mac_pipe_sat
module tb_mac_pipe_sat;
   logic clk = 1'b0;
   logic reset = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mac_pipe_sat_if #(.A_W(10), .B_W(10), .ACC_W(20)) bus ();
   mac_pipe_sat_if #(.A_W(16), .B_W(16), .ACC_W(40)) bus_w1 ();
   mac_pipe_sat_if #(.A_W(16), .B_W(16), .ACC_W(40)) bus_w8 ();

   mac_pipe_sat #(.A_W(10), .B_W(10), .ACC_W(20), .MULT_STAGES(5)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mac_pipe_sat #(.A_W(16), .B_W(16), .ACC_W(40), .MULT_STAGES(1)) u_dut_w1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w1)
   );

   mac_pipe_sat #(.A_W(16), .B_W(16), .ACC_W(40), .MULT_STAGES(8)) u_dut_w8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w8)
   );

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive the inputs for clock edge n, then land 1 time unit after that edge.
   task automatic cyc(input int av, input int bv, input bit v, input bit c, input bit r);
      @(negedge clk);
      bus.a        = 10'(av);
      bus.b        = 10'(bv);
      bus.valid_in = v;
      bus.clear_in = c;
      reset        = r;
      @(posedge clk);
      #1;
   endtask

   task automatic cycw(input longint av, input longint bv, input bit v, input bit c);
      @(negedge clk);
      bus_w1.a        = 16'(av);
      bus_w1.b        = 16'(bv);
      bus_w1.valid_in = v;
      bus_w1.clear_in = c;
      bus_w8.a        = 16'(av);
      bus_w8.b        = 16'(bv);
      bus_w8.valid_in = v;
      bus_w8.clear_in = c;
      @(posedge clk);
      #1;
   endtask

   task automatic exp_out(input string t, input int n, input bit ev, input longint ef,
                          input bit eov);
      check_eq($sformatf("%s_vo_c%0d", t, n), bus.valid_out, ev);
      check_eq($sformatf("%s_f_c%0d", t, n), bus.f, ef);
      check_eq($sformatf("%s_ov_c%0d", t, n), bus.overflow, eov);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit      ev;
      longint  ef;
      bit      eov;
      longint  mf;
      bit      mov;
      longint  sum;
      longint  wa, wb;
      bit      wv, wc, sat;
      longint  q1_f[$], q8_f[$];
      bit      q1_o[$], q8_o[$];
      longint  WMAX;
      longint  WMIN;

      WMAX = (64'sd1 <<< 39) - 1;
      WMIN = -(64'sd1 <<< 39);

      bus.a = '0; bus.b = '0; bus.valid_in = 1'b0; bus.clear_in = 1'b0;
      bus_w1.a = '0; bus_w1.b = '0; bus_w1.valid_in = 1'b0; bus_w1.clear_in = 1'b0;
      bus_w8.a = '0; bus_w8.b = '0; bus_w8.valid_in = 1'b0; bus_w8.clear_in = 1'b0;

      // Reset values
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      exp_out("rst", 0, 0, 0, 0);
      check_eq("rst_w1_vo", bus_w1.valid_out, 0);
      check_eq("rst_w8_f", bus_w8.f, 0);

      // Basic accumulation: 12, 2, -5 at cycles 7..9
      ef = 0; eov = 0;
      for (int n = 0; n < 11; n++) begin
         case (n)
            0: cyc(3, 4, 1, 1, 0);
            1: cyc(-2, 5, 1, 0, 0);
            2: cyc(7, -1, 1, 0, 0);
            default: cyc(0, 0, 0, 0, 0);
         endcase
         ev = 0;
         case (n)
            7: begin ev = 1; ef = 12; end
            8: begin ev = 1; ef = 2;  end
            9: begin ev = 1; ef = -5; end
            default: ;
         endcase
         exp_out("basic", n, ev, ef, eov);
      end

      // Positive saturation and recovery
      for (int n = 0; n < 11; n++) begin
         case (n)
            0: cyc(-512, -512, 1, 1, 0);
            1: cyc(-512, -512, 1, 0, 0);
            2: cyc(1, -1, 1, 0, 0);
            default: cyc(0, 0, 0, 0, 0);
         endcase
         ev = 0;
         case (n)
            7: begin ev = 1; ef = 262144; eov = 0; end
            8: begin ev = 1; ef = 524287; eov = 1; end
            9: begin ev = 1; ef = 524286; eov = 1; end
            default: ;
         endcase
         exp_out("psat", n, ev, ef, eov);
      end

      // Negative saturation, then a clear sample resets overflow
      for (int n = 0; n < 12; n++) begin
         case (n)
            0: cyc(511, -512, 1, 1, 0);
            1: cyc(511, -512, 1, 0, 0);
            2: cyc(511, -512, 1, 0, 0);
            3: cyc(2, 3, 1, 1, 0);
            default: cyc(0, 0, 0, 0, 0);
         endcase
         ev = 0;
         case (n)
            7:  begin ev = 1; ef = -261632; eov = 0; end
            8:  begin ev = 1; ef = -523264; eov = 0; end
            9:  begin ev = 1; ef = -524288; eov = 1; end
            10: begin ev = 1; ef = 6;       eov = 0; end
            default: ;
         endcase
         exp_out("nsat", n, ev, ef, eov);
      end

      // Gapped input; clear without valid on cycle 1 must be ignored
      for (int n = 0; n < 13; n++) begin
         case (n)
            0: cyc(1, 1, 1, 1, 0);
            1: cyc(9, 9, 0, 1, 0);
            3: cyc(2, 2, 1, 0, 0);
            4: cyc(3, 3, 1, 0, 0);
            default: cyc(0, 0, 0, 0, 0);
         endcase
         ev = 0;
         case (n)
            7:  begin ev = 1; ef = 1;  end
            10: begin ev = 1; ef = 5;  end
            11: begin ev = 1; ef = 14; end
            default: ;
         endcase
         exp_out("gap", n, ev, ef, eov);
      end

      // Reset mid-stream discards everything in flight
      for (int n = 0; n < 22; n++) begin
         case (n)
            0: cyc(1, 1, 1, 0, 0);
            1: cyc(2, 1, 1, 0, 0);
            2: cyc(3, 1, 1, 0, 0);
            3: cyc(4, 1, 1, 0, 1);
            13: cyc(5, 5, 1, 0, 0);
            default: cyc(0, 0, 0, 0, 0);
         endcase
         ev = 0;
         if (n == 3) ef = 0;
         if (n == 20) begin ev = 1; ef = 25; end
         exp_out("mrst", n, ev, ef, 0);
      end

      // Wide variants: latency 3 (MULT_STAGES=1) and 10 (MULT_STAGES=8)
      for (int n = 0; n < 12; n++) begin
         if (n == 0) cycw(1000, -3, 1, 1);
         else        cycw(0, 0, 0, 0);
         check_eq($sformatf("w1_lat_vo_c%0d", n), bus_w1.valid_out, (n == 3));
         check_eq($sformatf("w8_lat_vo_c%0d", n), bus_w8.valid_out, (n == 10));
         if (n == 3)  check_eq("w1_lat_f", bus_w1.f, -3000);
         if (n == 10) check_eq("w8_lat_f", bus_w8.f, -3000);
      end

      // Wide variants: streams against a saturating reference
      mf = 0; mov = 0;
      for (int n = 0; n < 1015; n++) begin
         wv = 0; wc = 0; wa = 0; wb = 0;
         if (n < 700) begin
            wv = (n == 0) || ($urandom_range(0, 9) != 0);
            wc = (n == 0);
            wa = -32768 + longint'($urandom_range(0, 200));
            wb = -32768 + longint'($urandom_range(0, 200));
         end else if (n < 1000) begin
            wv = ($urandom_range(0, 3) != 0);
            wc = ($urandom_range(0, 39) == 0);
            wa = longint'($urandom_range(0, 65535)) - 32768;
            wb = longint'($urandom_range(0, 65535)) - 32768;
         end
         cycw(wa, wb, wv, wc);
         if (wv) begin
            sum = (wc ? 64'sd0 : mf) + wa * wb;
            sat = 0;
            if (sum > WMAX) begin mf = WMAX; sat = 1; end
            else if (sum < WMIN) begin mf = WMIN; sat = 1; end
            else mf = sum;
            mov = wc ? sat : (mov | sat);
            q1_f.push_back(mf); q1_o.push_back(mov);
            q8_f.push_back(mf); q8_o.push_back(mov);
         end
         if (bus_w1.valid_out) begin
            check_eq("w1_pending", q1_f.size() != 0, 1);
            if (q1_f.size() != 0) begin
               check_eq($sformatf("w1_f_c%0d", n), bus_w1.f, q1_f.pop_front());
               check_eq($sformatf("w1_ov_c%0d", n), bus_w1.overflow, q1_o.pop_front());
            end
         end
         if (bus_w8.valid_out) begin
            check_eq("w8_pending", q8_f.size() != 0, 1);
            if (q8_f.size() != 0) begin
               check_eq($sformatf("w8_f_c%0d", n), bus_w8.f, q8_f.pop_front());
               check_eq($sformatf("w8_ov_c%0d", n), bus_w8.overflow, q8_o.pop_front());
            end
         end
      end
      check_eq("w1_drain", q1_f.size(), 0);
      check_eq("w8_drain", q8_f.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
